// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp : data-memory responder for the MIPS32 pipeline core.
//
// Services byte-enabled stores and one-cycle-latency loads from a word-wide
// RAM, and decodes a 4 KiB MMIO page containing an LED register, a
// free-running cycle counter and a RAM store counter.
//
// Ports
//   clk    in   1   single clock, rising-edge active
//   rst_n  in   1   asynchronous active-low reset
//   dce    in   1   access enable from the memory stage
//   daddr  in  32   byte address (bits [1:0] ignored)
//   we     in   4   byte-lane write enables, all zero = read
//   din    in  32   lane-aligned store data
//   dm     out 32   registered read data, valid the cycle after the request
//   led    out 32   LED register contents
// -----------------------------------------------------------------------------
module dmem_resp #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hBFD0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dce,
    input  logic [31:0] daddr,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    output logic [31:0] dm,
    output logic [31:0] led
);

    // Word offsets inside the MMIO page (daddr[11:2]).
    localparam logic [9:0] OFF_LED   = 10'd0;
    localparam logic [9:0] OFF_CYCLE = 10'd1;
    localparam logic [9:0] OFF_STCNT = 10'd2;

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem_r [0:DEPTH-1];
    logic [31:0]       led_r;
    logic [31:0]       cycle_r;
    logic [31:0]       stcnt_r;
    logic [31:0]       dm_r;

    logic              is_mmio_s;
    logic              is_rd_s;
    logic              is_wr_s;
    logic [ADDR_W-1:0] word_idx_s;
    logic [9:0]        mmio_off_s;
    logic [31:0]       rd_data_s;

    // Byte offset bits never take part in word accesses.
    logic              unused_addr_s;
    assign unused_addr_s = ^daddr[1:0];

    // Replace each byte of old_word whose lane enable is set with new_word's byte.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lane_en
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Address decode and access classification.
    always_comb begin
        is_mmio_s  = (daddr[31:12] == MMIO_BASE[31:12]);
        is_rd_s    = dce && (we == 4'b0000);
        is_wr_s    = dce && (we != 4'b0000);
        word_idx_s = daddr[ADDR_W+1:2];
        mmio_off_s = daddr[11:2];
    end

    // Read-data multiplexer; MMIO registers are sampled before this edge's update.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (is_mmio_s) begin
            case (mmio_off_s)
                OFF_LED:   rd_data_s = led_r;
                OFF_CYCLE: rd_data_s = cycle_r;
                OFF_STCNT: rd_data_s = stcnt_r;
                default:   rd_data_s = 32'h0000_0000;
            endcase
        end else begin
            rd_data_s = mem_r[word_idx_s];
        end
    end

    // RAM byte-lane write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (is_wr_s && !is_mmio_s) begin
            mem_r[word_idx_s] <= merge_bytes(mem_r[word_idx_s], din, we);
        end
    end

    // Read-data register: loads only on a read, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_r <= 32'h0000_0000;
        end else if (is_rd_s) begin
            dm_r <= rd_data_s;
        end
    end

    // LED register, byte-enabled writes at offset 0 of the MMIO page.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= 32'h0000_0000;
        end else if (is_wr_s && is_mmio_s && (mmio_off_s == OFF_LED)) begin
            led_r <= merge_bytes(led_r, din, we);
        end
    end

    // Free-running cycle counter; writes to it are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_r <= 32'h0000_0000;
        end else begin
            cycle_r <= cycle_r + 32'd1;
        end
    end

    // Store counter: one count per RAM write cycle, independent of lane count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stcnt_r <= 32'h0000_0000;
        end else if (is_wr_s && !is_mmio_s) begin
            stcnt_r <= stcnt_r + 32'd1;
        end
    end

    assign dm  = dm_r;
    assign led = led_r;

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

    logic        clk;
    logic        rst_n;
    logic        dce;
    logic [31:0] daddr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] dm;
    logic [31:0] led;

    int          pass_cnt;
    int          total_cnt;
    int unsigned n_edges;   // rising edges since reset release = expected CYCLE

    localparam logic [31:0] A_LED   = 32'hBFD0_0000;
    localparam logic [31:0] A_CYCLE = 32'hBFD0_0004;
    localparam logic [31:0] A_STCNT = 32'hBFD0_0008;

    dmem_resp #(.ADDR_W(10), .MMIO_BASE(32'hBFD0_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dce   (dce),
        .daddr (daddr),
        .we    (we),
        .din   (din),
        .dm    (dm),
        .led   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request, let it take the next rising edge, sample 1 ns later.
    task automatic access(input logic d, input logic [31:0] a,
                          input logic [3:0] w, input logic [31:0] di);
        dce   = d;
        daddr = a;
        we    = w;
        din   = di;
        @(posedge clk);
        n_edges = n_edges + 1;
        #1;
    endtask

    task automatic idle();
        access(1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dce = 1'b0; daddr = 32'h0; we = 4'h0; din = 32'h0;
        #1;
        total_cnt++;
        if (dm !== 32'h0) $display("FAIL reset_dm got=%h exp=%h", dm, 32'h0); else pass_cnt++;
        total_cnt++;
        if (led !== 32'h0) $display("FAIL reset_led got=%h exp=%h", led, 32'h0); else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_edges = 0;
        idle(); idle(); idle();
        access(1'b1, A_CYCLE, 4'h0, 32'h0);
        total_cnt++;
        if (dm !== 32'd3) $display("FAIL cycle_after_3 got=%h exp=%h", dm, 32'd3); else pass_cnt++;
        access(1'b1, A_LED, 4'h0, 32'h0);
        total_cnt++;
        if (dm !== 32'h0) $display("FAIL led_read_reset got=%h exp=%h", dm, 32'h0); else pass_cnt++;
        access(1'b1, A_STCNT, 4'h0, 32'h0);
        total_cnt++;
        if (dm !== 32'h0) $display("FAIL stcnt_reset got=%h exp=%h", dm, 32'h0); else pass_cnt++;
    endtask

    task automatic test_byte_write();
        access(1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344);
        access(1'b1, 32'h0000_0010, 4'b0101, 32'hAABB_CCDD);
        access(1'b1, 32'h0000_0010, 4'h0, 32'h0);
        total_cnt++;
        if (dm !== 32'h11BB_33DD) $display("FAIL byte_merge got=%h exp=%h", dm, 32'h11BB_33DD); else pass_cnt++;
        access(1'b1, A_STCNT, 4'h0, 32'h0);
        total_cnt++;
        if (dm !== 32'd2) $display("FAIL stcnt_two got=%h exp=%h", dm, 32'd2); else pass_cnt++;
    endtask

    task automatic test_alias();
        access(1'b1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF);
        access(1'b1, 32'h0000_0000, 4'h0, 32'h0);
        total_cnt++;
        if (dm !== 32'hDEAD_BEEF) $display("FAIL alias_read got=%h exp=%h", dm, 32'hDEAD_BEEF); else pass_cnt++;
        access(1'b1, A_LED, 4'h0, 32'h0);   // move dm away before the next read
        access(1'b1, 32'h0000_0003, 4'h0, 32'h0);
        total_cnt++;
        if (dm !== 32'hDEAD_BEEF) $display("FAIL alias_lowbits got=%h exp=%h", dm, 32'hDEAD_BEEF); else pass_cnt++;
    endtask

    task automatic test_mmio();
        int unsigned exp_cyc;
        access(1'b1, A_LED, 4'b0001, 32'h0000_00A5);
        total_cnt++;
        if (led !== 32'h0000_00A5) $display("FAIL led_write got=%h exp=%h", led, 32'h0000_00A5); else pass_cnt++;
        access(1'b1, A_LED, 4'b0010, 32'h0000_3C00);
        total_cnt++;
        if (led !== 32'h0000_3CA5) $display("FAIL led_lane1 got=%h exp=%h", led, 32'h0000_3CA5); else pass_cnt++;
        // MMIO writes must not count as stores: still 3 RAM writes so far.
        access(1'b1, A_STCNT, 4'h0, 32'h0);
        total_cnt++;
        if (dm !== 32'd3) $display("FAIL stcnt_mmio got=%h exp=%h", dm, 32'd3); else pass_cnt++;
        access(1'b1, A_CYCLE, 4'hF, 32'hFFFF_FFFF);
        exp_cyc = n_edges;
        access(1'b1, A_CYCLE, 4'h0, 32'h0);
        total_cnt++;
        if (dm !== exp_cyc) $display("FAIL cycle_ro got=%h exp=%h", dm, exp_cyc); else pass_cnt++;
        access(1'b1, A_CYCLE, 4'h0, 32'h0);
        total_cnt++;
        if (dm !== exp_cyc + 1) $display("FAIL cycle_next got=%h exp=%h", dm, exp_cyc + 1); else pass_cnt++;
        access(1'b1, 32'hBFD0_0100, 4'h0, 32'h0);
        total_cnt++;
        if (dm !== 32'h0) $display("FAIL unused_off got=%h exp=%h", dm, 32'h0); else pass_cnt++;
    endtask

    task automatic test_hold();
        access(1'b1, 32'h0000_0020, 4'hF, 32'h1234_5678);
        access(1'b1, 32'h0000_0020, 4'h0, 32'h0);
        total_cnt++;
        if (dm !== 32'h1234_5678) $display("FAIL hold_read got=%h exp=%h", dm, 32'h1234_5678); else pass_cnt++;
        idle();
        total_cnt++;
        if (dm !== 32'h1234_5678) $display("FAIL hold_idle1 got=%h exp=%h", dm, 32'h1234_5678); else pass_cnt++;
        idle();
        total_cnt++;
        if (dm !== 32'h1234_5678) $display("FAIL hold_idle2 got=%h exp=%h", dm, 32'h1234_5678); else pass_cnt++;
        access(1'b1, 32'h0000_0024, 4'hF, 32'h5555_AAAA);
        total_cnt++;
        if (dm !== 32'h1234_5678) $display("FAIL hold_write got=%h exp=%h", dm, 32'h1234_5678); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'hA0A0_0001;
        vals[1] = 32'hB1B1_0002;
        vals[2] = 32'hC2C2_0003;
        vals[3] = 32'hD3D3_0004;
        for (int i = 0; i < 4; i++) begin
            access(1'b1, 32'h0000_0040 + 32'(4 * i), 4'hF, vals[i]);
        end
        for (int i = 0; i < 4; i++) begin
            access(1'b1, 32'h0000_0040 + 32'(4 * i), 4'h0, 32'h0);
            total_cnt++;
            if (dm !== vals[i]) $display("FAIL stream_%0d got=%h exp=%h", i, dm, vals[i]); else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        access(1'b1, 32'h0000_0020, 4'h0, 32'h0);
        // Next read is in flight when reset drops between edges.
        daddr = 32'h0000_0040;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (dm !== 32'h0) $display("FAIL midrst_dm got=%h exp=%h", dm, 32'h0); else pass_cnt++;
        total_cnt++;
        if (led !== 32'h0) $display("FAIL midrst_led got=%h exp=%h", led, 32'h0); else pass_cnt++;
        daddr = A_CYCLE;
        #2;
        rst_n = 1'b1;
        n_edges = 0;
        access(1'b1, A_CYCLE, 4'h0, 32'h0);
        total_cnt++;
        if (dm !== 32'h0) $display("FAIL midrst_cycle0 got=%h exp=%h", dm, 32'h0); else pass_cnt++;
        access(1'b1, A_CYCLE, 4'h0, 32'h0);
        total_cnt++;
        if (dm !== 32'd1) $display("FAIL midrst_cycle1 got=%h exp=%h", dm, 32'd1); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        n_edges   = 0;
        test_reset();
        test_byte_write();
        test_alias();
        test_mmio();
        test_hold();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the MIPS32 pipeline core. It sits on the far side of the core's data-memory port (`dce`, `daddr`, `we`, `din` in, `dm` out). It services byte-enabled stores and single-cycle-latency loads from a word-organised RAM. It also decodes a small memory-mapped I/O page holding an LED register, a free-running cycle counter and a store counter.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address bits of the RAM; depth is 2^ADDR_W words (4 KiB at default).
- `MMIO_BASE`, default 32'hBFD0_0000: base of the 4 KiB MMIO page; only bits [31:12] are compared.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dce`  in  1  access enable from the core's memory stage.
- `daddr`  in  32  byte address; bits [1:0] are ignored.
- `we`  in  4  byte-lane write enables; `we[i]` writes `din[8i+7:8i]`; all zero means read.
- `din`  in  32  store data, already lane-aligned by the core.
- `dm`  out  32  registered read data, consumed by the write-back stage one cycle after the request.
- `led`  out  32  LED register contents.

## Operation
Address decode:
- An access is MMIO when `daddr[31:12] == MMIO_BASE[31:12]`; otherwise it is RAM.
- RAM word index is `daddr[ADDR_W+1:2]`. Upper bits are ignored, so the RAM aliases across the address space.

Access type:
- Read when `dce=1` and `we=4'b0000`.
- Write when `dce=1` and `we!=0`.
- Idle when `dce=0`.

RAM:
- Write: at the clock edge, each byte lane `i` with `we[i]=1` is updated; other lanes keep their contents. `dm` is not updated on a write cycle.
- Read: at the clock edge, `dm` is loaded with the addressed word.
- Contents are not reset.

MMIO registers (offset = `daddr[11:2]`):
- 0x000 LED: read/write, byte-enabled like RAM, drives `led`.
- 0x004 CYCLE: read-only, free-running 32-bit counter; +1 every cycle; wraps from 0xFFFF_FFFF to 0.
- 0x008 STCNT: read-only 32-bit count of completed RAM write cycles. One count per cycle regardless of how many lanes are enabled. Wraps.
- Writes to read-only offsets and to unused offsets are silently dropped.
- Reads of unused offsets return 0.
- MMIO writes do not increment STCNT.

Ordering rules:
- `dm` holds its last value whenever no read is performed (idle or write cycle).
- A read of CYCLE at edge t returns the counter value present before edge t's increment.
- A read of STCNT returns its value before any update at the same edge.
- A read of LED returns its value before any update at the same edge. (A read and a write never coincide, since a cycle is one or the other.)

## Timing
- Reset (`rst_n=0`, asynchronous): `dm=0`, `led=0`, CYCLE=0, STCNT=0. RAM is untouched.
- CYCLE counting:
  - CYCLE holds at 0 while reset is asserted.
  - The first increment happens on the first rising edge after `rst_n` rises.
  - Reset asserted mid-access aborts the access: no RAM write is guaranteed, and `dm` is forced to 0.
- Read latency: request presented in cycle n is sampled at the edge ending cycle n; `dm` is valid throughout cycle n+1.
- Back-to-back reads, one per cycle, are supported with no bubbles.
- Write followed by a read of the same word in the next cycle returns the newly written data (store-to-load, no hazard).
- No handshake or stall: every request completes in one cycle, and the block never back-pressures the core.

## Test plan
- Reset, then 3 idle cycles, then read 0x0000_0000 is not checked. Read MMIO 0xBFD0_0000 -> `dm=0`, `led=0`. Read 0xBFD0_0004 immediately after 3 post-reset edges -> `dm=3`.
- Byte-enabled RAM write:
  - Write 0x1122_3344 `we=4'hF` to 0x0000_0010.
  - Then write 0xAABB_CCDD `we=4'b0101` to the same address.
  - Then read it -> `dm=0x11BB_33DD` in the following cycle.
  - STCNT reads back 2.
- Aliasing: write 0xDEAD_BEEF to 0x0000_1000 with ADDR_W=10, then read 0x0000_0000 -> `dm=0xDEAD_BEEF`. Address bits [1:0]=2'b11 on the read give the same result.
- MMIO:
  - Write 0x0000_00A5 `we=4'b0001` to 0xBFD0_0000 -> `led=0x0000_00A5` from the next cycle.
  - Write 0xFFFF_FFFF to 0xBFD0_0004 -> CYCLE continues counting unaffected.
  - Read 0xBFD0_0100 -> `dm=0`.
- Hold and streaming:
  - Read A (0x1234_5678), then 2 idle cycles, then a write -> `dm` stays 0x1234_5678 across all three cycles.
  - Four consecutive reads of distinct words -> four distinct values on consecutive cycles.
- Assert `rst_n=0` mid-cycle during a read -> `dm` goes 0 immediately (without a clock edge), `led=0`, and CYCLE reads 0 after release plus 0 edges.
